// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: round-robin arbiter sharing one register-access bus among
// NUM_REQ config masters and routing each transaction to one of NUM_SLV slaves.
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   req_valid/_ready/_write       per-requester handshake and direction
//   req_sel/_addr/_wdata          packed per-requester slave index, address, data
//   rsp_valid/_rdata/_err         one-cycle response to the owning requester
//   slv_wr_en/_rd_en              one-hot slave strobes
//   slv_address/_write_data       shared slave address and write data
//   slv_read_data                 packed read data from every slave
module cfg_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [NUM_SLV-1:0]          slv_wr_en,
    output logic [NUM_SLV-1:0]          slv_rd_en,
    output logic [ADDR_W-1:0]           slv_address,
    output logic [DATA_W-1:0]           slv_write_data,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_read_data
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SEL_N    = 1 << SEL_W;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    // Pointer doubles as the grantee index once a request has been taken.
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               write_q, write_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SLV-1:0] wr_en_q, wr_en_d;
    logic [NUM_SLV-1:0] rd_en_q, rd_en_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [SEL_W-1:0]   sel_arr   [NUM_REQ];
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    // Sized to the full select range so an out-of-range select reads zero.
    logic [DATA_W-1:0]  rd_arr    [SEL_N];

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    int unsigned        cand;
    logic               sel_ok;

    // Unpack the flat request and read-data buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_arr[i]   = req_sel[i*SEL_W +: SEL_W];
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
        for (int unsigned i = 0; i < SEL_N; i++) begin
            rd_arr[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            rd_arr[i] = slv_read_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting one past the last grantee.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_found && req_valid[PTR_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
    end

    // Ready is gated by reset so nothing is accepted while the block is held.
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_ok = (32'(sel_q) < NUM_SLV);

    // Next-state and registered-output logic; strobes and responses are
    // computed one cycle early so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        write_d     = write_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        wr_en_d     = '0;
        rd_en_d     = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    ptr_d   = gnt_idx;
                    write_d = req_write[gnt_idx];
                    sel_d   = sel_arr[gnt_idx];
                    addr_d  = addr_arr[gnt_idx];
                    wdata_d = wdata_arr[gnt_idx];
                    if (32'(sel_arr[gnt_idx]) < NUM_SLV) begin
                        if (req_write[gnt_idx]) begin
                            wr_en_d = NUM_SLV'(1) << sel_arr[gnt_idx];
                        end else begin
                            rd_en_d = NUM_SLV'(1) << sel_arr[gnt_idx];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!sel_ok) begin
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << ptr_q;
                    state_d     = RESP;
                end else if (write_q) begin
                    rsp_valid_d = NUM_REQ'(1) << ptr_q;
                    state_d     = RESP;
                end else if (RD_LAT == 0) begin
                    rsp_rdata_d = rd_arr[sel_q];
                    rsp_valid_d = NUM_REQ'(1) << ptr_q;
                    state_d     = RESP;
                end else begin
                    cnt_d   = CNT_W'(CNT_INIT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = rd_arr[sel_q];
                    rsp_valid_d = NUM_REQ'(1) << ptr_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            write_q     <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            wr_en_q     <= '0;
            rd_en_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign slv_wr_en      = wr_en_q;
    assign slv_rd_en      = rd_en_q;
    assign slv_address    = addr_q;
    assign slv_write_data = wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// tb_cfg_bus_arbiter: directed bench for cfg_bus_arbiter with three instances
// (default config, 3 slaves with zero read latency, read latency 3) and a
// response scoreboard filled at accept time and drained by a response monitor.
module tb_cfg_bus_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned SW = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NR-1:0]    req_write = '0;
    logic [NR*SW-1:0] req_sel   = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    rv [3];

    logic [NR-1:0] a_rdy, a_rspv, b_rdy, b_rspv, c_rdy, c_rspv;
    logic [DW-1:0] a_rspd, b_rspd, c_rspd, a_swd, b_swd, c_swd;
    logic          a_rspe, b_rspe, c_rspe;
    logic [3:0]    a_wr, a_rd, c_wr, c_rd;
    logic [2:0]    b_wr, b_rd;
    logic [AW-1:0] a_sadr, b_sadr, c_sadr;
    logic [4*DW-1:0] a_srd, c_srd;
    logic [3*DW-1:0] b_srd;

    cfg_bus_arbiter u_dut (
        .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(a_rdy),
        .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rspv), .rsp_rdata(a_rspd), .rsp_err(a_rspe),
        .slv_wr_en(a_wr), .slv_rd_en(a_rd), .slv_address(a_sadr),
        .slv_write_data(a_swd), .slv_read_data(a_srd)
    );

    cfg_bus_arbiter #(.NUM_SLV(3), .RD_LAT(0)) u_err (
        .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(b_rdy),
        .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rspv), .rsp_rdata(b_rspd), .rsp_err(b_rspe),
        .slv_wr_en(b_wr), .slv_rd_en(b_rd), .slv_address(b_sadr),
        .slv_write_data(b_swd), .slv_read_data(b_srd)
    );

    cfg_bus_arbiter #(.RD_LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(c_rdy),
        .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(c_rspv), .rsp_rdata(c_rspd), .rsp_err(c_rspe),
        .slv_wr_en(c_wr), .slv_rd_en(c_rd), .slv_address(c_sadr),
        .slv_write_data(c_swd), .slv_read_data(c_srd)
    );

    // Slave models: data is valid only exactly RD_LAT cycles after rd_en,
    // garbage (0xEE) otherwise, so mistimed captures are visible.
    logic [DW-1:0] sval [4];
    logic [3:0] a_rdp = '0, c_p1 = '0, c_p2 = '0, c_p3 = '0;
    always @(posedge clock) begin
        a_rdp <= a_rd;
        c_p1  <= c_rd;
        c_p2  <= c_p1;
        c_p3  <= c_p2;
    end
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            a_srd[s*DW +: DW] = a_rdp[s] ? sval[s] : 8'hEE;
            c_srd[s*DW +: DW] = c_p3[s] ? sval[s] : 8'hEE;
        end
        for (int s = 0; s < 3; s++) begin
            b_srd[s*DW +: DW] = b_rd[s] ? sval[s] : 8'hEE;
        end
    end

    // View of the instance currently being driven.
    int cur = 0;
    logic [NR-1:0] m_rdy;
    logic [3:0]    m_wr, m_rd;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wd;
    always_comb begin
        case (cur)
            1: begin m_rdy = b_rdy; m_wr = {1'b0, b_wr}; m_rd = {1'b0, b_rd}; m_adr = b_sadr; m_wd = b_swd; end
            2: begin m_rdy = c_rdy; m_wr = c_wr; m_rd = c_rd; m_adr = c_sadr; m_wd = c_swd; end
            default: begin m_rdy = a_rdy; m_wr = a_wr; m_rd = a_rd; m_adr = a_sadr; m_wd = a_swd; end
        endcase
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            inst;
        logic [NR-1:0] vld;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t sb [$];

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int r, input int k);
        return AW'(r * 8 + k);
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int r, input int k);
        return DW'(16 * (k + 1) + r);
    endfunction

    task automatic set_fields(input int r, input int k);
        req_write[r]          = 1'b1;
        req_sel[r*SW +: SW]   = SW'(k);
        req_addr[r*AW +: AW]  = addr_of(r, k);
        req_wdata[r*DW +: DW] = wdata_of(r, k);
    endtask

    task automatic push_exp(input int inst, input int r, input logic [DW-1:0] d, input logic e, input int c);
        exp_t x;
        x.inst  = inst;
        x.vld   = NR'(1) << r;
        x.rdata = d;
        x.err   = e;
        x.cyc   = c;
        sb.push_back(x);
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    task automatic mon(input int i, input logic [NR-1:0] v, input logic [DW-1:0] d, input logic e,
                       input logic [3:0] w, input logic [3:0] r);
        exp_t x;
        check($sformatf("strobe_onehot_i%0d", i), 32'($countones({w, r}) <= 1), 32'(1));
        if (v === '0) begin
            check($sformatf("rsp_idle_zero_i%0d", i), 32'({d, e}), 32'(0));
        end else if (sb.size() == 0) begin
            check($sformatf("unexpected_rsp_i%0d", i), 32'(v), 32'(0));
        end else begin
            x = sb.pop_front();
            check("rsp_inst", 32'(i), 32'(x.inst));
            check("rsp_valid", 32'(v), 32'(x.vld));
            check("rsp_rdata", 32'(d), 32'(x.rdata));
            check("rsp_err", 32'(e), 32'(x.err));
            check("rsp_cycle", 32'(cyc), 32'(x.cyc));
        end
    endtask

    always @(negedge clock) begin
        mon(0, a_rspv, a_rspd, a_rspe, a_wr, a_rd);
        mon(1, b_rspv, b_rspd, b_rspe, {1'b0, b_wr}, {1'b0, b_rd});
        mon(2, c_rspv, c_rspd, c_rspe, c_wr, c_rd);
    end

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
            #1;
        end
        check("drain", 32'(sb.size()), 32'(0));
    endtask

    // Single transaction from one requester; checks accept, strobe cycle and
    // that the strobe lasts exactly one cycle.
    task automatic issue(input int inst, input int r, input logic wr, input logic [SW-1:0] sel,
                         input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_d, input logic exp_e, input int lat,
                         input bit exp_rsp, input logic [3:0] exp_wr, input logic [3:0] exp_rd);
        bit got;
        @(negedge clock);
        cur                   = inst;
        req_write[r]          = wr;
        req_sel[r*SW +: SW]   = sel;
        req_addr[r*AW +: AW]  = adr;
        req_wdata[r*DW +: DW] = wd;
        rv[inst][r]           = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (m_rdy[r] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("accept", 32'(got), 32'(1));
        check("ready_onehot", 32'(m_rdy), 32'(NR'(1) << r));
        if (exp_rsp) push_exp(inst, r, exp_d, exp_e, cyc + 2 + lat);
        @(posedge clock);
        #1;
        check("ready_busy", 32'(m_rdy), 32'(0));
        rv[inst][r] = 1'b0;
        check("wr_en", 32'(m_wr), 32'(exp_wr));
        check("rd_en", 32'(m_rd), 32'(exp_rd));
        check("slv_address", 32'(m_adr), 32'(adr));
        if (wr) check("slv_write_data", 32'(m_wd), 32'(wd));
        @(posedge clock);
        #1;
        check("strobe_single", 32'({m_wr, m_rd}), 32'(0));
    endtask

    // Both requesters hold valid for per_req writes each; grants must alternate.
    task automatic arb_run(input int inst, input int per_req);
        int kk [NR];
        int last;
        int g;
        bit got;
        cur = inst;
        for (int r = 0; r < NR; r++) begin
            kk[r] = 0;
            set_fields(r, 0);
        end
        rv[inst] = '1;
        last = 0;
        for (int n = 0; n < NR * per_req; n++) begin
            g = n % NR;
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (m_rdy !== '0) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            check("arb_accept", 32'(got), 32'(1));
            check("arb_grant", 32'(m_rdy), 32'(NR'(1) << g));
            if (n > 0) check("arb_spacing", 32'(cyc - last), 32'(3));
            last = cyc;
            push_exp(inst, g, '0, 1'b0, cyc + 2);
            @(posedge clock);
            #1;
            check("arb_wr_en", 32'(m_wr), 32'(4'(1) << kk[g]));
            check("arb_rd_en", 32'(m_rd), 32'(0));
            check("arb_addr", 32'(m_adr), 32'(addr_of(g, kk[g])));
            check("arb_wdata", 32'(m_wd), 32'(wdata_of(g, kk[g])));
            kk[g]++;
            if (kk[g] == per_req) rv[inst][g] = 1'b0;
            else set_fields(g, kk[g]);
            @(negedge clock);
        end
        drain();
    endtask

    initial begin
        reset = 1'b0;
        rv[0] = '0;
        rv[1] = '0;
        rv[2] = '0;
        sval[0] = 8'h11; sval[1] = 8'h22; sval[2] = 8'h33; sval[3] = 8'h44;
        repeat (2) @(negedge clock);

        // Reset state, with requests pending
        rv[0] = '1;
        #1;
        check("rst_ready", 32'(a_rdy), 32'(0));
        check("rst_strobes", 32'({a_wr, a_rd}), 32'(0));
        check("rst_rsp", 32'({a_rspv, a_rspd, a_rspe}), 32'(0));
        check("rst_bus", 32'({a_sadr, a_swd}), 32'(0));
        rv[0] = '0;
        @(negedge clock);
        reset = 1'b1;

        // Write, then read with RD_LAT=1, then out-of-range select
        issue(0, 0, 1'b1, 3'd2, 4'h5, 8'hA5, 8'h00, 1'b0, 0, 1'b1, 4'b0100, 4'b0000);
        drain();
        sval[1] = 8'h3C;
        issue(0, 1, 1'b0, 3'd1, 4'h3, 8'h00, 8'h3C, 1'b0, 1, 1'b1, 4'b0000, 4'b0010);
        drain();
        issue(0, 0, 1'b1, 3'd5, 4'h7, 8'h77, 8'h00, 1'b1, 0, 1'b1, 4'b0000, 4'b0000);
        drain();

        // Fairness from reset
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        arb_run(0, 4);

        // Error on a 3-slave instance, then latency sweep
        issue(1, 0, 1'b0, 3'd3, 4'h2, 8'h00, 8'h00, 1'b1, 0, 1'b1, 4'b0000, 4'b0000);
        drain();
        sval[2] = 8'h5A;
        issue(1, 1, 1'b0, 3'd2, 4'hA, 8'h00, 8'h5A, 1'b0, 0, 1'b1, 4'b0000, 4'b0100);
        drain();
        sval[1] = 8'h5A;
        issue(2, 0, 1'b0, 3'd1, 4'h6, 8'h00, 8'h5A, 1'b0, 3, 1'b1, 4'b0000, 4'b0010);
        drain();

        // Reset while waiting on read data: transaction is dropped
        sval[3] = 8'hC3;
        issue(2, 1, 1'b0, 3'd3, 4'h9, 8'h00, 8'h00, 1'b0, 3, 1'b0, 4'b0000, 4'b1000);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_strobes", 32'({c_wr, c_rd}), 32'(0));
        check("midrst_rsp", 32'({c_rspv, c_rspd, c_rspe}), 32'(0));
        check("midrst_bus", 32'({c_sadr, c_swd}), 32'(0));
        set_fields(0, 0);
        set_fields(1, 0);
        rv[2] = '1;
        #1;
        check("midrst_ready", 32'(c_rdy), 32'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        arb_run(2, 1);

        repeat (6) @(negedge clock);
        #1;
        check("sb_empty_end", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
